// File: rtl/frame_tx_1001_if.sv
// Handshake and serial-line bundle for the 1001-sync frame transmitter.
interface frame_tx_1001_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              op;
  logic              op_valid;
  logic              busy;

  // Upstream producer / line observer side.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  op,
    input  op_valid,
    input  busy
  );

  // Transmitter side.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output op,
    output op_valid,
    output busy
  );
endinterface

// File: rtl/frame_tx_1001.sv
// Serial frame transmitter: preamble 1001, payload MSB-first, then GAP idle zeros.
// All outputs are registered and decoded from the next state, so the first
// preamble bit appears right after the accepting edge.
module frame_tx_1001 #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned GAP    = 2
) (
  input logic           clk,
  input logic           reset,
  frame_tx_1001_if.slave bus
);

  localparam int unsigned CntMax = (DATA_W > GAP) ? ((DATA_W > 4) ? DATA_W : 4)
                                                  : ((GAP > 4) ? GAP : 4);
  localparam int unsigned CntW = $clog2(CntMax);

  localparam logic [CntW-1:0] PreLast  = CntW'(3);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP - 1);
  localparam logic [3:0]      Preamble = 4'b1001;

  typedef enum logic [1:0] {StIdle, StPre, StData, StGap} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              op_q, op_d;
  logic              op_valid_q, op_valid_d;
  logic              busy_q, busy_d;
  logic              in_ready_q, in_ready_d;
  logic              accept;

  assign accept       = bus.in_valid && in_ready_q;
  assign bus.op       = op_q;
  assign bus.op_valid = op_valid_q;
  assign bus.busy     = busy_q;
  assign bus.in_ready = in_ready_q;

  // State, datapath and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sh_q       <= '0;
      op_q       <= 1'b0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next state: the counter indexes the bit currently on the line within each phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StPre;
          cnt_d   = '0;
          sh_d    = bus.in_data;
        end
      end
      StPre: begin
        if (cnt_q == PreLast) begin
          state_d = StData;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        // MSB of the shift register is always the payload bit being sent.
        sh_d = sh_q << 1;
        if (cnt_q == DataLast) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore output decode from the next state, captured by the output registers.
  always_comb begin
    op_d       = 1'b0;
    op_valid_d = 1'b0;
    busy_d     = 1'b0;
    in_ready_d = 1'b0;
    unique case (state_d)
      StIdle: begin
        in_ready_d = 1'b1;
      end
      StPre: begin
        op_d       = Preamble[2'd3 - cnt_d[1:0]];
        op_valid_d = 1'b1;
        busy_d     = 1'b1;
      end
      StData: begin
        op_d       = sh_d[DATA_W-1];
        op_valid_d = 1'b1;
        busy_d     = 1'b1;
      end
      StGap: begin
        busy_d = 1'b1;
      end
      default: begin
        in_ready_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_frame_tx_1001.sv
// Directed bench for frame_tx_1001: default instance plus a DATA_W=1/GAP=1 corner.
module tb_frame_tx_1001;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  frame_tx_1001_if #(.DATA_W(8)) bus ();
  frame_tx_1001_if #(.DATA_W(1)) bus1 ();

  frame_tx_1001 #(.DATA_W(8), .GAP(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  frame_tx_1001 #(.DATA_W(1), .GAP(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_op, input logic e_vld,
                            input logic e_busy, input logic e_rdy);
    check({tag, ".op"}, bus.op, e_op);
    check({tag, ".op_valid"}, bus.op_valid, e_vld);
    check({tag, ".busy"}, bus.busy, e_busy);
    check({tag, ".in_ready"}, bus.in_ready, e_rdy);
  endtask

  // Sends one frame on the default instance from a cycle where in_ready=1.
  // mode 0: drop in_valid after acceptance; 1: hold in_valid; 2: noise on in_valid/in_data.
  task automatic run_frame(input logic [7:0] d, input int mode, input string tag);
    logic [13:0] bits;
    bits = {4'b1001, d, 2'b00};
    check({tag, ".pre_ready"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (mode == 0) bus.in_valid = 1'b0;
      if (mode == 2) begin
        bus.in_valid = ~bus.in_valid;
        bus.in_data  = 8'($urandom);
      end
      check_outs($sformatf("%s[%0d]", tag, i), bits[13-i], (i < 12), 1'b1, 1'b0);
    end
    tick();
    check_outs($sformatf("%s.end", tag), 1'b0, 1'b0, 1'b0, 1'b1);
    if (mode != 1) bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [5:0] bits1;
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5A;
    bus1.in_valid = 1'b0;
    bus1.in_data  = 1'b0;

    // Reset held with in_valid asserted: nothing accepted, outputs quiet.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("reset[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    tick();
    check_outs("release", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Single frame.
    run_frame(8'hA5, 0, "single");
    tick();

    // Back-to-back with in_valid held: second acceptance 15 cycles after the first.
    run_frame(8'hA5, 1, "b2b_a");
    run_frame(8'h3C, 0, "b2b_b");
    tick();

    // Upstream noise while busy must not disturb the frame.
    run_frame(8'hF0, 2, "noise");
    tick();
    check_outs("noise.idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset during the third payload bit of 8'hC6 (bit 5 = 0).
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC6;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    check_outs("midrst.pre", 1'b0, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    tick();
    check_outs("midrst.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    check_outs("midrst.rel", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("midrst.idle", 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(8'h81, 0, "after_rst");

    // Corner instance: DATA_W=1, GAP=1, payload 1 -> 1,0,0,1,1,0; period 7.
    bits1         = 6'b100110;
    bus1.in_valid = 1'b1;
    bus1.in_data  = 1'b1;
    check("c1.pre_ready", bus1.in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("c1[%0d].op", i), bus1.op, bits1[5-i]);
      check($sformatf("c1[%0d].op_valid", i), bus1.op_valid, (i < 5));
      check($sformatf("c1[%0d].busy", i), bus1.busy, 1'b1);
      check($sformatf("c1[%0d].in_ready", i), bus1.in_ready, 1'b0);
    end
    tick();
    check("c1.end.in_ready", bus1.in_ready, 1'b1);
    check("c1.end.op_valid", bus1.op_valid, 1'b0);
    tick();
    check("c1.next.op", bus1.op, 1'b1);
    check("c1.next.op_valid", bus1.op_valid, 1'b1);
    check("c1.next.in_ready", bus1.in_ready, 1'b0);
    bus1.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
